// File: rtl/sp_align_rx.sv
// rtl/sp_align_rx.sv - serial lane receiver: COM-based byte alignment, lock, parallel byte output
// Optional lock-loss timeout on long data runs is enabled by defining SP_TIMEOUT_EN.
module sp_align_rx #(
   parameter logic [7:0]  COM_SYMBOL     = 8'hBC,
   parameter int unsigned COM_LOCK_COUNT = 4
`ifdef SP_TIMEOUT_EN
   ,
   parameter int unsigned MAX_DATA_RUN   = 64
`endif
) (
   input  logic       clk_8f,
   input  logic       reset_L,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active,
   output logic       lock_lost
);

   localparam logic [3:0] LP_LOCK = 4'(COM_LOCK_COUNT);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_LOCKING = 2'd1,
      ST_ALIGNED = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_shift;
   logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic [3:0]  r_com_cnt, w_com_cnt_nxt, w_com_inc;
   logic [7:0]  r_data, w_data_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_strobe, w_strobe_nxt;
   logic        w_is_com, w_boundary;

`ifdef SP_TIMEOUT_EN
   localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
   localparam logic [RUN_W-1:0] LP_RUN_MAX = RUN_W'(MAX_DATA_RUN);
   logic [RUN_W-1:0] r_run_cnt, w_run_cnt_nxt, w_run_inc;
   logic             r_lock_lost, w_lock_lost_nxt;
   assign w_run_inc = r_run_cnt + 1'b1;
`endif

   assign w_is_com   = (r_shift == COM_SYMBOL);
   assign w_boundary = (r_bit_cnt == 3'd0);
   assign w_com_inc  = (r_com_cnt >= LP_LOCK) ? r_com_cnt : r_com_cnt + 4'd1;

   always_ff @(posedge clk_8f) begin
      if (!reset_L) begin
         r_state   <= ST_SEARCH;
         r_shift   <= 8'd0;
         r_bit_cnt <= 3'd0;
         r_com_cnt <= 4'd0;
         r_data    <= 8'd0;
         r_valid   <= 1'b0;
         r_strobe  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= {r_shift[6:0], serial_in};
         r_bit_cnt <= w_bit_cnt_nxt;
         r_com_cnt <= w_com_cnt_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
         r_strobe  <= w_strobe_nxt;
      end
   end

`ifdef SP_TIMEOUT_EN
   always_ff @(posedge clk_8f) begin
      if (!reset_L) begin
         r_run_cnt   <= '0;
         r_lock_lost <= 1'b0;
      end else begin
         r_run_cnt   <= w_run_cnt_nxt;
         r_lock_lost <= w_lock_lost_nxt;
      end
   end
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      w_com_cnt_nxt = r_com_cnt;
      w_data_nxt    = r_data;
      w_valid_nxt   = r_valid;
      w_strobe_nxt  = 1'b0;
`ifdef SP_TIMEOUT_EN
      w_run_cnt_nxt   = r_run_cnt;
      w_lock_lost_nxt = 1'b0;
`endif
      case (r_state)
         ST_SEARCH: begin
            // Bit-sliding search: a match fixes the byte phase, next check 8 bits later
            w_bit_cnt_nxt = 3'd0;
            if (w_is_com) begin
               w_bit_cnt_nxt = 3'd1;
               w_com_cnt_nxt = 4'd1;
               w_state_nxt   = (LP_LOCK == 4'd1) ? ST_ALIGNED : ST_LOCKING;
            end
         end
         ST_LOCKING: begin
            if (w_boundary) begin
               if (w_is_com) begin
                  w_com_cnt_nxt = w_com_inc;
                  if (w_com_inc >= LP_LOCK) w_state_nxt = ST_ALIGNED;
               end else begin
                  w_state_nxt   = ST_SEARCH;
                  w_com_cnt_nxt = 4'd0;
                  w_bit_cnt_nxt = 3'd0;
               end
            end
         end
         ST_ALIGNED: begin
            if (w_boundary) begin
               w_strobe_nxt = 1'b1;
               if (w_is_com) begin
                  w_valid_nxt   = 1'b0;
                  w_com_cnt_nxt = w_com_inc;
`ifdef SP_TIMEOUT_EN
                  w_run_cnt_nxt = '0;
`endif
               end else begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
`ifdef SP_TIMEOUT_EN
                  // The byte that hits the limit is still delivered before lock drops
                  if (w_run_inc == LP_RUN_MAX) begin
                     w_state_nxt     = ST_SEARCH;
                     w_lock_lost_nxt = 1'b1;
                     w_com_cnt_nxt   = 4'd0;
                     w_run_cnt_nxt   = '0;
                     w_bit_cnt_nxt   = 3'd0;
                  end else begin
                     w_run_cnt_nxt = w_run_inc;
                  end
`endif
               end
            end
         end
         default: begin
            w_state_nxt   = ST_SEARCH;
            w_bit_cnt_nxt = 3'd0;
            w_com_cnt_nxt = 4'd0;
         end
      endcase
   end

   assign data_out    = r_data;
   assign valid_out   = r_valid;
   assign byte_strobe = r_strobe;
   assign active      = (r_state == ST_ALIGNED);
`ifdef SP_TIMEOUT_EN
   assign lock_lost   = r_lock_lost;
`else
   assign lock_lost   = 1'b0;
`endif

endmodule

// File: tb/tb_sp_align_rx.sv
// tb/tb_sp_align_rx.sv - self-checking bench for sp_align_rx with a byte-level reference model
module tb_sp_align_rx;

   localparam logic [7:0] COM     = 8'hBC;
   localparam int         LOCK    = 4;
   localparam int         MAX_RUN = 64;

   logic       clk_8f = 1'b0;
   logic       reset_L = 1'b0;
   logic       serial_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out, byte_strobe, active, lock_lost;

   always #5 clk_8f = ~clk_8f;

   sp_align_rx dut (
      .clk_8f      (clk_8f),
      .reset_L     (reset_L),
      .serial_in   (serial_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active),
      .lock_lost   (lock_lost)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: last 8 received bits, alignment mode (0 search, 1 locking, 2 aligned),
   // edge index of the next byte check, COM count, data-run length, expected outputs.
   logic [7:0] m_hist, m_data;
   logic       m_valid, m_strobe, m_lost;
   int         m_mode, m_ncom, m_run, m_edge, m_next;

   logic [8:0] log_q[$];
   int         lost_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   function automatic logic [8:0] log_at(input int i);
      if (i < log_q.size()) return log_q[i];
      return 9'h1FF;
   endfunction

   task automatic model_step(input logic b, input logic rstn);
      logic [7:0] w;
      if (!rstn) begin
         m_hist = 8'd0; m_data = 8'd0; m_valid = 1'b0; m_strobe = 1'b0; m_lost = 1'b0;
         m_mode = 0; m_ncom = 0; m_run = 0; m_edge = 0; m_next = 0;
         return;
      end
      w        = m_hist;
      m_strobe = 1'b0;
      m_lost   = 1'b0;
      if (m_mode == 0) begin
         if (w == COM) begin
            m_ncom = 1;
            m_next = m_edge + 8;
            m_mode = (LOCK == 1) ? 2 : 1;
         end
      end else if (m_edge == m_next) begin
         m_next = m_next + 8;
         if (m_mode == 1) begin
            if (w == COM) begin
               m_ncom++;
               if (m_ncom >= LOCK) m_mode = 2;
            end else begin
               m_mode = 0;
               m_ncom = 0;
            end
         end else begin
            m_strobe = 1'b1;
            if (w == COM) begin
               m_valid = 1'b0;
               m_run   = 0;
            end else begin
               m_data  = w;
               m_valid = 1'b1;
`ifdef SP_TIMEOUT_EN
               m_run++;
               if (m_run == MAX_RUN) begin
                  m_mode = 0; m_lost = 1'b1; m_run = 0; m_ncom = 0;
               end
`endif
            end
         end
      end
      m_hist = {m_hist[6:0], b};
      m_edge++;
   endtask

   task automatic compare_outputs();
      chk("active",      active,      (m_mode == 2));
      chk("byte_strobe", byte_strobe, m_strobe);
      chk("valid_out",   valid_out,   m_valid);
      chk("data_out",    data_out,    m_data);
      chk("lock_lost",   lock_lost,   m_lost);
   endtask

   task automatic tick(input logic b, input logic rstn);
      serial_in = b;
      reset_L   = rstn;
      @(posedge clk_8f);
      model_step(b, rstn);
      @(negedge clk_8f);
      compare_outputs();
      if (byte_strobe === 1'b1) log_q.push_back({valid_out, data_out});
      if (lock_lost === 1'b1) lost_cnt++;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) tick(v[i], 1'b1);
   endtask

   initial begin
      lost_cnt = 0;

      // 1: reset with random line activity
      for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0);
      chk("rst_active", active, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);

      // 2: four COMs at bit offset 3, then two data bytes and a trailing COM
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(COM);
      chk("t2_active_after_lock", active, 0);
      send_byte(8'h5A);
      chk("t2_active_after_lock", active, 1);
      send_byte(8'hC3);
      send_byte(COM);
      tick(1'b0, 1'b1);
      chk("t2_log_size", log_q.size(), 3);
      chk("t2_byte0", log_at(0), 9'h15A);
      chk("t2_byte1", log_at(1), 9'h1C3);
      chk("t2_byte2", log_at(2), 9'h0C3);

      tick(1'b0, 1'b0);
      log_q.delete();

      // 3 + 4: a data byte breaks LOCKING; four fresh COMs lock, then A1,COM,B2
      send_byte(COM);
      send_byte(COM);
      send_byte(8'h11);
      send_byte(COM);
      send_byte(COM);
      send_byte(COM);
      send_byte(COM);
      chk("t3_not_yet_active", active, 0);
      send_byte(8'hA1);
      chk("t3_active", active, 1);
      send_byte(COM);
      send_byte(8'hB2);
      tick(1'b0, 1'b1);
      chk("t4_log_size", log_q.size(), 3);
      chk("t4_byte0", log_at(0), 9'h1A1);
      chk("t4_byte1", log_at(1), 9'h0A1);
      chk("t4_byte2", log_at(2), 9'h1B2);
      chk("t4_data_out", data_out, 8'hB2);

      // 5: reset in the middle of a byte while aligned
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      chk("t5_rst_active", active, 0);
      chk("t5_rst_valid", valid_out, 0);
      chk("t5_rst_data", data_out, 0);
      chk("t5_rst_strobe", byte_strobe, 0);
      log_q.delete();
      lost_cnt = 0;
      for (int i = 0; i < 4; i++) send_byte(COM);
      chk("t5_relock_pending", active, 0);

      // 6: long data run without COM
      for (int k = 1; k <= MAX_RUN; k++) begin
         send_byte(8'(k));
         if (k == 1) chk("t5_relocked", active, 1);
      end
      tick(1'b0, 1'b1);
      chk("t6_log_size", log_q.size(), MAX_RUN);
      chk("t6_last_byte", log_at(MAX_RUN - 1), 9'h140);
`ifdef SP_TIMEOUT_EN
      chk("t6_lock_lost_pulse", lock_lost, 1);
      chk("t6_active_dropped", active, 0);
      tick(1'b0, 1'b1);
      chk("t6_lock_lost_once", lost_cnt, 1);
`else
      chk("t6_no_lock_lost", lost_cnt, 0);
      chk("t6_still_active", active, 1);
`endif
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
